trdb_resync_scheduler: RTL and testbench
========================================

# trdb_resync_scheduler

Runtime-configurable resynchronisation scheduler for the trace encoder. It counts either cycles or emitted packets against a programmable threshold. When the threshold is reached, or on a forced request, it raises a sticky resync request, and holds it until the packet emitter acknowledges that a sync packet has been sent. It sits between the filter/config registers and the packet emitter. It is the parametrised, handshaked successor of the fixed-threshold resync counter.

## Interface
Parameters:
- CNT_W, 16, counter and threshold width.
- DEFAULT_MAX, 16'hFFFF, threshold after reset (CNT_W bits).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- trace_enabled_i  in  1  trace enable from filter.
- mode_i  in  2  resync_mode_e: 0 OFF, 1 CYCLE, 2 PACKET; 3 is treated as OFF.
- packet_emitted_i  in  1  one packet emitted this cycle.
- cfg_max_i  in  CNT_W  new threshold.
- cfg_load_i  in  1  threshold write strobe.
- force_resync_i  in  1  external resync request pulse.
- resync_ack_i  in  1  sync packet emitted this cycle.
- resync_req_o  out  1  resync request, level, held until ack.
- et_resync_max_o  out  1  cnt_q == max_q-1.
- gt_resync_max_o  out  1  cnt_q >= max_q.
- count_o  out  CNT_W  current count.

## Operation
- State: max_q (CNT_W), cnt_q (CNT_W) and state_q (resync_state_e: IDLE, COUNT, PENDING).
- Reset values: max_q=DEFAULT_MAX, cnt_q=0, state_q=IDLE, every output 0.
- The block is active when trace_enabled_i=1 and mode_i is CYCLE or PACKET.
- inc = active && state_q==COUNT && (mode_i==CYCLE || (mode_i==PACKET && packet_emitted_i)).
- Per-cycle priority, highest first:
  1. Not active: state→IDLE, cnt→0. The request drops.
  2. cfg_load_i: max→cfg_max_i, except that 0 loads as 1. cnt→0. state→COUNT if it was not IDLE.
  3. IDLE and active: state→PENDING, so the first traced packet is a sync. cnt stays 0.
  4. resync_ack_i: cnt→0, state→COUNT. In the same cycle, a force_resync_i in COUNT or PENDING overrides this to state→PENDING with cnt=0, so a forced request is never lost.
  5. force_resync_i in COUNT: state→PENDING, cnt unchanged.
  6. inc: cnt_d=cnt_q+1. If cnt_d==max_q, state→PENDING.
- PENDING behaviour: cnt is frozen and stays saturated at or below max_q. No wrap-around occurs. Extra packets or cycles are ignored.
- Arithmetic: cnt never exceeds max_q, so no overflow is possible at CNT_W. The max_q-1 comparison is done in CNT_W bits, and max_q≥1 is guaranteed.
- A cfg_load_i that lowers max_q below cnt_q is safe, because the load clears cnt.

## Timing
- resync_req_o = (state_q==PENDING), registered decode.
- et, gt and count_o are combinational from cnt_q and max_q only, never from inputs.
- An inc at cycle t gives cnt_q+1 at t+1. If this hits max_q, resync_req_o and gt are both 1 at t+1.
- An ack at t gives resync_req_o=0 and cnt_q=0 at t+1.
- A force at t gives resync_req_o=1 at t+1.
- An enable rising at t gives resync_req_o=1 at t+1.
- A disable at t gives req=0 and cnt=0 at t+1, including mid-PENDING.
- A load at t makes the new max_q visible at t+1.
- The ack handshake needs no minimum spacing. Back-to-back ack and force are legal every cycle.
- Asynchronous reset at any point returns to reset values immediately.

## Structure
- trdb_pkg gains resync_mode_e (2 bits: RSYNC_OFF, RSYNC_CYCLE, RSYNC_PACKET) and resync_state_e (2 bits: RS_IDLE, RS_COUNT, RS_PENDING).
- The block is a single module with no sub-module. It has one always_ff for max_q, cnt_q and state_q, and one always_comb for next-state and priority.

## Test plan
- Reset held, then released with enable=0 -> all outputs 0, count_o=0. After enabling CYCLE mode, resync_req_o=1 one cycle later.
- CYCLE mode, load max=4, ack the initial request -> count_o steps 0,1,2,3. et=1 at count 3. At count 4, req=1 and gt=1. With no ack for 10 cycles, count stays 4. On ack, req=0 and count=0 the next cycle.
- PACKET mode, max=3, packet_emitted_i on alternate cycles -> count increments only after packet cycles. req rises the cycle after the third packet.
- COUNT at count 2, force_resync_i -> PENDING with count=2. Ack and force in the same cycle -> PENDING with count=0. Ack and inc in the same cycle in COUNT -> count=0.
- PENDING, then trace_enabled_i dropped -> req=0 and count=0 the next cycle. Re-enabling gives req=1 again.
- cfg_load_i with cfg_max_i=0 -> max becomes 1 and et=1 at count 0. mode_i=3 behaves as OFF: IDLE, no request.

Source files
------------

// File: rtl/trdb_pkg.sv
// Shared trace-debug types: resynchronisation mode and scheduler state encodings.
package trdb_pkg;

   typedef enum logic [1:0] {
      RSYNC_OFF    = 2'd0,
      RSYNC_CYCLE  = 2'd1,
      RSYNC_PACKET = 2'd2
   } resync_mode_e;

   typedef enum logic [1:0] {
      RS_IDLE    = 2'd0,
      RS_COUNT   = 2'd1,
      RS_PENDING = 2'd2
   } resync_state_e;

endpackage

// File: rtl/trdb_resync_scheduler.sv
// Resync scheduler: counts cycles or packets against a programmable threshold and
// holds a sticky resync request until the packet emitter acknowledges the sync.
module trdb_resync_scheduler
   import trdb_pkg::*;
#(
   parameter int unsigned        CNT_W       = 16,
   parameter logic [CNT_W-1:0]   DEFAULT_MAX = 16'hFFFF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             trace_enabled_i,
   input  logic [1:0]       mode_i,
   input  logic             packet_emitted_i,
   input  logic [CNT_W-1:0] cfg_max_i,
   input  logic             cfg_load_i,
   input  logic             force_resync_i,
   input  logic             resync_ack_i,
   output logic             resync_req_o,
   output logic             et_resync_max_o,
   output logic             gt_resync_max_o,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] max_q, max_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   resync_state_e    state_q, state_d;

   logic mode_cycle, mode_packet, active, inc;

   assign mode_cycle  = (mode_i == RSYNC_CYCLE);
   assign mode_packet = (mode_i == RSYNC_PACKET);
   assign active      = trace_enabled_i && (mode_cycle || mode_packet);
   assign inc         = active && (state_q == RS_COUNT) &&
                        (mode_cycle || (mode_packet && packet_emitted_i));

   always_comb begin
      max_d   = max_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      if (!active) begin
         state_d = RS_IDLE;
         cnt_d   = '0;
      end else if (cfg_load_i) begin
         // A zero threshold would make max_q-1 wrap, so it is clamped to 1.
         max_d = (cfg_max_i == '0) ? CNT_W'(1) : cfg_max_i;
         cnt_d = '0;
         if (state_q != RS_IDLE) state_d = RS_COUNT;
      end else if (state_q == RS_IDLE) begin
         state_d = RS_PENDING;
      end else if (resync_ack_i) begin
         cnt_d   = '0;
         state_d = force_resync_i ? RS_PENDING : RS_COUNT;
      end else if (force_resync_i && state_q == RS_COUNT) begin
         state_d = RS_PENDING;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_d == max_q) state_d = RS_PENDING;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         max_q   <= DEFAULT_MAX;
         cnt_q   <= '0;
         state_q <= RS_IDLE;
      end else begin
         max_q   <= max_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign resync_req_o    = (state_q == RS_PENDING);
   assign et_resync_max_o = (cnt_q == (max_q - CNT_W'(1)));
   assign gt_resync_max_o = (cnt_q >= max_q);
   assign count_o         = cnt_q;

endmodule

// File: tb/tb_trdb_resync_scheduler.sv
// Directed, table-driven bench for trdb_resync_scheduler with hand-computed expectations.
module tb_trdb_resync_scheduler;

   logic        clk;
   logic        rst_ni;
   logic        trace_enabled_i;
   logic [1:0]  mode_i;
   logic        packet_emitted_i;
   logic [15:0] cfg_max_i;
   logic        cfg_load_i;
   logic        force_resync_i;
   logic        resync_ack_i;
   logic        resync_req_o;
   logic        et_resync_max_o;
   logic        gt_resync_max_o;
   logic [15:0] count_o;

   int unsigned checks = 0;
   int unsigned errors = 0;

   trdb_resync_scheduler #(.CNT_W(16), .DEFAULT_MAX(16'hFFFF)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .trace_enabled_i  (trace_enabled_i),
      .mode_i           (mode_i),
      .packet_emitted_i (packet_emitted_i),
      .cfg_max_i        (cfg_max_i),
      .cfg_load_i       (cfg_load_i),
      .force_resync_i   (force_resync_i),
      .resync_ack_i     (resync_ack_i),
      .resync_req_o     (resync_req_o),
      .et_resync_max_o  (et_resync_max_o),
      .gt_resync_max_o  (gt_resync_max_o),
      .count_o          (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [1:0]  mode;
      logic        pkt;
      logic        load;
      logic [15:0] cfg;
      logic        frc;
      logic        ack;
      int unsigned rep;
      logic        req;
      logic        et;
      logic        gt;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic en, logic [1:0] mode, logic pkt, logic load,
                               logic [15:0] cfg, logic frc, logic ack, int unsigned rep,
                               logic req, logic et, logic gt, logic [15:0] cnt);
      vec_t v;
      v.en = en; v.mode = mode; v.pkt = pkt; v.load = load; v.cfg = cfg;
      v.frc = frc; v.ack = ack; v.rep = rep;
      v.req = req; v.et = et; v.gt = gt; v.cnt = cnt;
      return v;
   endfunction

   task automatic check(string name, logic req, logic et, logic gt, logic [15:0] cnt);
      checks++;
      if ({resync_req_o, et_resync_max_o, gt_resync_max_o, count_o} !== {req, et, gt, cnt}) begin
         errors++;
         $display("FAIL %s: got req=%b et=%b gt=%b cnt=%0d, expected req=%b et=%b gt=%b cnt=%0d",
                  name, resync_req_o, et_resync_max_o, gt_resync_max_o, count_o,
                  req, et, gt, cnt);
      end
   endtask

   task automatic drive(logic en, logic [1:0] mode, logic pkt, logic load,
                        logic [15:0] cfg, logic frc, logic ack);
      trace_enabled_i  = en;
      mode_i           = mode;
      packet_emitted_i = pkt;
      cfg_load_i       = load;
      cfg_max_i        = cfg;
      force_resync_i   = frc;
      resync_ack_i     = ack;
   endtask

   initial begin
      rst_ni = 1'b0;
      drive(1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);

      //           en mode pkt ld cfg  frc ack rep  req et gt cnt
      vecs.push_back(mk(0, 2'd0, 0, 0, 16'd0, 0, 0, 1,  0, 0, 0, 16'd0)); // 1 disabled
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 0, 1,  1, 0, 0, 16'd0)); // 2 enable -> req
      vecs.push_back(mk(1, 2'd1, 0, 1, 16'd4, 0, 0, 1,  0, 0, 0, 16'd0)); // 3 load 4 -> COUNT
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 0, 1,  0, 0, 0, 16'd1)); // 4
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 0, 1,  0, 0, 0, 16'd2)); // 5
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 0, 1,  0, 1, 0, 16'd3)); // 6 et
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 0, 1,  1, 0, 1, 16'd4)); // 7 hit max
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 0, 10, 1, 0, 1, 16'd4)); // 8 saturated
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 1, 1,  0, 0, 0, 16'd0)); // 9 ack
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 0, 1,  0, 0, 0, 16'd1)); // 10
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 0, 1,  0, 0, 0, 16'd2)); // 11
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 1, 0, 1,  1, 0, 0, 16'd2)); // 12 force, cnt kept
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 1, 1, 1,  1, 0, 0, 16'd0)); // 13 ack+force
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 1, 1,  0, 0, 0, 16'd0)); // 14 ack
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 0, 1,  0, 0, 0, 16'd1)); // 15
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 1, 1,  0, 0, 0, 16'd0)); // 16 ack beats inc
      vecs.push_back(mk(1, 2'd2, 0, 1, 16'd3, 0, 0, 1,  0, 0, 0, 16'd0)); // 17 packet, max 3
      vecs.push_back(mk(1, 2'd2, 1, 0, 16'd0, 0, 0, 1,  0, 0, 0, 16'd1)); // 18
      vecs.push_back(mk(1, 2'd2, 0, 0, 16'd0, 0, 0, 1,  0, 0, 0, 16'd1)); // 19
      vecs.push_back(mk(1, 2'd2, 1, 0, 16'd0, 0, 0, 1,  0, 1, 0, 16'd2)); // 20
      vecs.push_back(mk(1, 2'd2, 0, 0, 16'd0, 0, 0, 1,  0, 1, 0, 16'd2)); // 21
      vecs.push_back(mk(1, 2'd2, 1, 0, 16'd0, 0, 0, 1,  1, 0, 1, 16'd3)); // 22 third packet
      vecs.push_back(mk(1, 2'd2, 1, 0, 16'd0, 0, 0, 1,  1, 0, 1, 16'd3)); // 23 frozen
      vecs.push_back(mk(0, 2'd2, 0, 0, 16'd0, 0, 0, 1,  0, 0, 0, 16'd0)); // 24 disable mid-PENDING
      vecs.push_back(mk(1, 2'd2, 0, 0, 16'd0, 0, 0, 1,  1, 0, 0, 16'd0)); // 25 re-enable
      vecs.push_back(mk(1, 2'd2, 0, 1, 16'd0, 0, 0, 1,  0, 1, 0, 16'd0)); // 26 load 0 -> max 1
      vecs.push_back(mk(1, 2'd2, 0, 0, 16'd0, 0, 0, 1,  0, 1, 0, 16'd0)); // 27 no packet
      vecs.push_back(mk(1, 2'd2, 1, 0, 16'd0, 0, 0, 1,  1, 0, 1, 16'd1)); // 28 hit max 1
      vecs.push_back(mk(1, 2'd3, 0, 0, 16'd0, 0, 0, 1,  0, 1, 0, 16'd0)); // 29 mode 3 = off
      vecs.push_back(mk(1, 2'd3, 1, 0, 16'd0, 1, 0, 3,  0, 1, 0, 16'd0)); // 30 stays off
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 0, 1,  1, 1, 0, 16'd0)); // 31 cycle -> req
      vecs.push_back(mk(0, 2'd1, 0, 1, 16'd5, 0, 0, 1,  0, 1, 0, 16'd0)); // 32 load ignored when off
      vecs.push_back(mk(1, 2'd1, 0, 1, 16'd5, 0, 0, 1,  0, 0, 0, 16'd0)); // 33 load in IDLE stays IDLE
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 0, 1,  1, 0, 0, 16'd0)); // 34 IDLE -> PENDING
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 1, 1, 1,  1, 0, 0, 16'd0)); // 35 ack+force in PENDING
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 1, 1,  0, 0, 0, 16'd0)); // 36 ack
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 1, 0, 1,  1, 0, 0, 16'd0)); // 37 force at cnt 0
      vecs.push_back(mk(1, 2'd1, 0, 1, 16'd0, 0, 0, 1,  0, 1, 0, 16'd0)); // 38 load 0 in PENDING
      vecs.push_back(mk(1, 2'd1, 0, 0, 16'd0, 0, 0, 1,  1, 0, 1, 16'd1)); // 39 hit max 1

      #12;
      check("reset_held", 1'b0, 1'b0, 1'b0, 16'd0);
      rst_ni = 1'b1;
      #1;
      check("reset_released", 1'b0, 1'b0, 1'b0, 16'd0);

      foreach (vecs[i]) begin
         for (int unsigned r = 0; r < vecs[i].rep; r++) begin
            drive(vecs[i].en, vecs[i].mode, vecs[i].pkt, vecs[i].load,
                  vecs[i].cfg, vecs[i].frc, vecs[i].ack);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_r%0d", i + 1, r), vecs[i].req, vecs[i].et,
                  vecs[i].gt, vecs[i].cnt);
         end
      end

      // Asynchronous reset mid-PENDING must clear state without a clock edge,
      // and restore the default threshold (et=0 at cnt 0 proves max != 1).
      drive(1'b1, 2'd1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
      #2;
      rst_ni = 1'b0;
      #1;
      check("async_reset", 1'b0, 1'b0, 1'b0, 16'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_enable", 1'b1, 1'b0, 1'b0, 16'd0);
      drive(1'b1, 2'd1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("post_reset_ack", 1'b0, 1'b0, 1'b0, 16'd0);
      drive(1'b1, 2'd1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
      for (int unsigned k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("default_max_count%0d", k), 1'b0, 1'b0, 1'b0, 16'(k));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
